// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start/slew controller stepping the PWM duty toward a target at period boundaries.
// Define PWM_RAMP_ABORT_EN to add the abort input that freezes a ramp at its current duty.
module pwm_ramp_ctrl #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PWM_RAMP_ABORT_EN
    input  logic             abort,
`endif
    input  logic             tgt_vld,
    output logic             tgt_rdy,
    input  logic [WIDTH-1:0] tgt_duty,
    output logic [WIDTH-1:0] duty,
    output logic             period_start,
    output logic             busy,
    output logic             done
);
    localparam int              DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int              WP1        = WIDTH + 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [WIDTH:0]  STEP_EXT   = WP1'(STEP);
    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] tgt_r;
    logic [DW-1:0]    dcnt_r;
    logic             tick_s;
    logic             up_s;
    logic             last_step_s;
    logic             abort_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] next_duty_s;

    assign tick_s = (cnt_r == {WIDTH{1'b1}});

`ifdef PWM_RAMP_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Distance to target in WIDTH+1 bits; a final partial step lands exactly on tgt, so no overshoot or wrap
    always_comb begin
        up_s        = 1'b0;
        diff_s      = {WP1{1'b0}};
        next_duty_s = duty;
        last_step_s = 1'b0;
        if (tgt_r > duty) begin
            up_s   = 1'b1;
            diff_s = {1'b0, tgt_r} - {1'b0, duty};
        end else begin
            up_s   = 1'b0;
            diff_s = {1'b0, duty} - {1'b0, tgt_r};
        end
        if (diff_s <= STEP_EXT) begin
            last_step_s = 1'b1;
            next_duty_s = tgt_r;
        end else if (up_s) begin
            last_step_s = 1'b0;
            next_duty_s = duty + STEP_W;
        end else begin
            last_step_s = 1'b0;
            next_duty_s = duty - STEP_W;
        end
    end

    // Free-running PWM period counter and the period_start pulse that follows its wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r        <= {WIDTH{1'b0}};
            period_start <= 1'b0;
        end else begin
            cnt_r        <= cnt_r + 1'b1;
            period_start <= tick_s;
        end
    end

    // Handshake / ramp FSM; duty only changes on the tick edge so it is stable for a whole period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            dcnt_r  <= {DW{1'b0}};
            tgt_r   <= {WIDTH{1'b0}};
            duty    <= {WIDTH{1'b0}};
            tgt_rdy <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (tgt_vld) begin
                        tgt_r   <= tgt_duty;
                        dcnt_r  <= {DW{1'b0}};
                        tgt_rdy <= 1'b0;
                        if (tgt_duty == duty) begin
                            state_r <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_r <= RAMP;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                end
                RAMP: begin
                    if (abort_s) begin
                        tgt_r   <= duty;
                        dcnt_r  <= {DW{1'b0}};
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (tick_s) begin
                        if (dcnt_r == DWELL_LAST) begin
                            dcnt_r <= {DW{1'b0}};
                            duty   <= next_duty_s;
                            if (last_step_s) begin
                                state_r <= DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            dcnt_r <= dcnt_r + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    tgt_rdy <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    dcnt_r  <= {DW{1'b0}};
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    tgt_rdy <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl: three parameterisations checked cycle by cycle against a
// step-list/timing model, driven from a vector table, hand sequences and random targets.
module tb_pwm_ramp_ctrl;
    logic       clk;
    logic       rst;
    logic       vld   [3];
    logic [7:0] tduty [3];
    logic       rdy   [3];
    logic [7:0] duty  [3];
    logic       ps    [3];
    logic       busy  [3];
    logic       done  [3];
`ifdef PWM_RAMP_ABORT_EN
    logic       abort [3];
`endif

    int step_p  [3] = '{1, 16, 1};
    int dwell_p [3] = '{1, 1, 3};
    int exp_duty[3];
    int cyc;
    int checks;
    int failures;

    typedef struct {
        int inst;
        int tgt;
        bit hold;
        int steps;
        int fin;
    } vec_t;
    vec_t tbl[9];

    pwm_ramp_ctrl #(.WIDTH(8), .STEP(1), .DWELL(1)) u_dut0 (
        .clk(clk), .rst(rst),
`ifdef PWM_RAMP_ABORT_EN
        .abort(abort[0]),
`endif
        .tgt_vld(vld[0]), .tgt_rdy(rdy[0]), .tgt_duty(tduty[0]), .duty(duty[0]),
        .period_start(ps[0]), .busy(busy[0]), .done(done[0])
    );
    pwm_ramp_ctrl #(.WIDTH(8), .STEP(16), .DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst),
`ifdef PWM_RAMP_ABORT_EN
        .abort(abort[1]),
`endif
        .tgt_vld(vld[1]), .tgt_rdy(rdy[1]), .tgt_duty(tduty[1]), .duty(duty[1]),
        .period_start(ps[1]), .busy(busy[1]), .done(done[1])
    );
    pwm_ramp_ctrl #(.WIDTH(8), .STEP(1), .DWELL(3)) u_dut2 (
        .clk(clk), .rst(rst),
`ifdef PWM_RAMP_ABORT_EN
        .abort(abort[2]),
`endif
        .tgt_vld(vld[2]), .tgt_rdy(rdy[2]), .tgt_duty(tduty[2]), .duty(duty[2]),
        .period_start(ps[2]), .busy(busy[2]), .done(done[2])
    );

    always #5 clk = ~clk;

    // Clocks elapsed since reset release; cyc % 256 is the PWM counter phase
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_duty(input int i, input int v, input int lim, input string name);
        int k = 0;
        while (int'(duty[i]) != v && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(name, int'(duty[i]), v);
    endtask

    // Called at a negedge with instance i idle; model: list of duties from the step rule,
    // step j becomes visible after tick number DWELL*(j+1) counted from the accept cycle
    task automatic run_ramp(input int i, input int t, input bit hold, input int exp_steps, input int exp_fin);
        int    d0, d, k0, fin, nsteps, e_duty, bad, changes, prev;
        int    sq[$];
        bit    e_busy, e_done, e_rdy, e_ps;
        string first;
        d0 = exp_duty[i];
        d  = d0;
        while (d != t) begin
            if (((t > d) ? t - d : d - t) <= step_p[i]) d = t;
            else if (t > d) d = d + step_p[i];
            else d = d - step_p[i];
            sq.push_back(d);
        end
        chk($sformatf("rdy_idle[%0d]", i), int'(rdy[i]), 1);
        k0  = ((cyc % 256) == 255) ? 256 : 255 - (cyc % 256);
        fin = (sq.size() == 0) ? 0 : k0 + (dwell_p[i] - 1 + (sq.size() - 1) * dwell_p[i]) * 256;
        vld[i]   = 1'b1;
        tduty[i] = 8'(t);
        bad = 0; changes = 0; prev = d0; first = "";
        for (int n = 1; n <= fin + 2; n++) begin
            @(negedge clk);
            if (n == 1) begin
                if (hold) tduty[i] = 8'(t ^ 8'h5A);
                else      vld[i] = 1'b0;
            end
            nsteps = 0;
            for (int j = 0; j < sq.size(); j++)
                if (k0 + (dwell_p[i] - 1 + j * dwell_p[i]) * 256 <= n - 1) nsteps = j + 1;
            e_duty = (nsteps == 0) ? d0 : sq[nsteps - 1];
            e_busy = (sq.size() != 0) && (n <= fin);
            e_done = (n == fin + 1);
            e_rdy  = (n >= fin + 2);
            e_ps   = ((cyc % 256) == 0) && (cyc != 0);
            if (int'(duty[i]) != prev) changes++;
            prev = int'(duty[i]);
            if (int'(duty[i]) != e_duty || busy[i] != e_busy || done[i] != e_done ||
                rdy[i] != e_rdy || ps[i] != e_ps) begin
                if (bad == 0)
                    first = $sformatf("n=%0d duty=%0d/%0d busy=%0b/%0b done=%0b/%0b rdy=%0b/%0b ps=%0b/%0b",
                                      n, duty[i], e_duty, busy[i], e_busy, done[i], e_done,
                                      rdy[i], e_rdy, ps[i], e_ps);
                bad++;
            end
            if (n == fin + 1) vld[i] = 1'b0;
        end
        chk($sformatf("trace[%0d] %0d->%0d deviating_cycles", i, d0, t), bad, 0);
        if (bad != 0) $display("  first deviation (got/expected): %s", first);
        if (exp_steps >= 0) chk($sformatf("steps[%0d] %0d->%0d", i, d0, t), changes, exp_steps);
        if (exp_fin >= 0)   chk($sformatf("final[%0d] %0d->%0d", i, d0, t), int'(duty[i]), exp_fin);
        exp_duty[i] = t;
    endtask

    initial begin : main
        int t;
        int d0;
        int e;
        clk = 1'b0;
        rst = 1'b1;
        checks = 0;
        failures = 0;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0;
            tduty[i] = 8'h00;
            exp_duty[i] = 0;
`ifdef PWM_RAMP_ABORT_EN
            abort[i] = 1'b0;
`endif
        end
        tbl[0] = '{0,   4, 1'b0,  4,   4};
        tbl[1] = '{0,   4, 1'b0,  0,   4};
        tbl[2] = '{1,  40, 1'b0,  3,  40};
        tbl[3] = '{1,   0, 1'b0,  3,   0};
        tbl[4] = '{1, 250, 1'b0, 16, 250};
        tbl[5] = '{1, 255, 1'b0,  1, 255};
        tbl[6] = '{2,   2, 1'b1,  2,   2};
        tbl[7] = '{0,  16, 1'b0, 12,  16};
        tbl[8] = '{0,  16, 1'b0,  0,  16};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_duty[%0d]", i), int'(duty[i]), 0);
            chk($sformatf("rst_busy[%0d]", i), int'(busy[i]), 0);
            chk($sformatf("rst_done[%0d]", i), int'(done[i]), 0);
            chk($sformatf("rst_rdy[%0d]", i),  int'(rdy[i]),  1);
            chk($sformatf("rst_ps[%0d]", i),   int'(ps[i]),   0);
        end
        rst = 1'b0;

        // Ramp 0->0x20 interrupted by an asynchronous reset once duty reaches 0x08
        vld[0] = 1'b1;
        tduty[0] = 8'h20;
        @(negedge clk);
        vld[0] = 1'b0;
        wait_duty(0, 8, 2600, "mid_ramp_reach_08");
        chk("mid_ramp_busy", int'(busy[0]), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_duty", int'(duty[0]), 0);
        chk("arst_busy", int'(busy[0]), 0);
        chk("arst_done", int'(done[0]), 0);
        chk("arst_rdy",  int'(rdy[0]),  1);
        chk("arst_ps",   int'(ps[0]),   0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 9; k++)
            run_ramp(tbl[k].inst, tbl[k].tgt, tbl[k].hold, tbl[k].steps, tbl[k].fin);

        for (int r = 0; r < 8; r++) begin
            t = exp_duty[0] + int'($urandom_range(0, 8)) - 4;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            run_ramp(0, t, 1'b0, -1, t);
        end
        for (int r = 0; r < 4; r++) begin
            t = int'($urandom_range(0, 255));
            run_ramp(1, t, (r % 2) == 1, -1, t);
        end
        for (int r = 0; r < 3; r++) begin
            t = exp_duty[2] + int'($urandom_range(0, 6)) - 3;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            run_ramp(2, t, 1'b1, -1, t);
        end

`ifdef PWM_RAMP_ABORT_EN
        // Abort right after the first step: duty freezes, done pulses, back to IDLE
        d0 = exp_duty[0];
        t  = (d0 >= 128) ? d0 - 20 : d0 + 20;
        e  = (t > d0) ? d0 + 1 : d0 - 1;
        vld[0] = 1'b1;
        tduty[0] = 8'(t);
        @(negedge clk);
        vld[0] = 1'b0;
        wait_duty(0, e, 600, "abort_first_step");
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("abort_duty_hold", int'(duty[0]), e);
        chk("abort_done",      int'(done[0]), 1);
        chk("abort_busy",      int'(busy[0]), 0);
        @(negedge clk);
        chk("abort_done_gone", int'(done[0]), 0);
        chk("abort_rdy",       int'(rdy[0]),  1);
        repeat (300) @(negedge clk);
        chk("abort_duty_stays", int'(duty[0]), e);
        exp_duty[0] = e;
`else
        d0 = 0;
        e  = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
